// File: rtl/cv32e40p_apu_resp_pkg.sv
// cv32e40p_apu_resp_pkg
// Shared types and constants for the APU responder: op-class enum, the
// pipeline slot record and the opcode-to-class decode helper.
package cv32e40p_apu_resp_pkg;

  typedef enum logic {
    OC_ADDMUL = 1'b0,
    OC_OTHERS = 1'b1
  } op_class_e;

  localparam int ADDMUL_OP_LIMIT = 8;
  localparam int APU_NUSFLAGS    = 5;
  localparam int APU_NDSFLAGS    = 15;

  // One in-flight op; an empty slot is kept all-zero so it can drive the
  // outputs directly without extra masking.
  typedef struct packed {
    logic                    valid;
    logic [31:0]             result;
    logic [APU_NUSFLAGS-1:0] flags;
  } slot_t;

  function automatic op_class_e decode_class(input logic [31:0] op);
    return (op < 32'(ADDMUL_OP_LIMIT)) ? OC_ADDMUL : OC_OTHERS;
  endfunction

endpackage

// File: rtl/cv32e40p_apu_resp_slot_pipe.sv
// cv32e40p_apu_resp_slot_pipe
// MAXL-deep completion pipe. Slot k holds the op that leaves the pipe k
// cycles from now; every cycle all slots move one step toward slot 0.
// A new op is written at slot wr_idx_i in the same cycle as the shift.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   wr_en_i         write a new op this cycle
//   wr_idx_i        destination slot (latency - 1)
//   wr_slot_i       op record to write
//   head_o          current content of slot 0 (leaves at the next edge)
//   last_rem_o      index of the youngest valid slot, 0 when empty
module cv32e40p_apu_resp_slot_pipe
  import cv32e40p_apu_resp_pkg::*;
#(
  parameter int MAXL = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [2:0]  wr_idx_i,
  input  slot_t       wr_slot_i,
  output slot_t       head_o,
  output logic [2:0]  last_rem_o
);

  slot_t slots_q [MAXL];
  slot_t slots_d [MAXL];

  always_comb begin
    for (int k = 0; k < MAXL; k++) begin
      if (k < MAXL-1) slots_d[k] = slots_q[k+1];
      else            slots_d[k] = '0;
      // The grant rule guarantees the shifted-in content of the write slot
      // is empty, so the overwrite never drops an op.
      if (wr_en_i && (wr_idx_i == 3'(k))) slots_d[k] = wr_slot_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < MAXL; k++) slots_q[k] <= '0;
    end else begin
      for (int k = 0; k < MAXL; k++) slots_q[k] <= slots_d[k];
    end
  end

  always_comb begin
    last_rem_o = 3'd0;
    for (int k = 0; k < MAXL; k++)
      if (slots_q[k].valid) last_rem_o = 3'(k);
  end

  assign head_o = slots_q[0];

endmodule

// File: rtl/cv32e40p_apu_responder.sv
// cv32e40p_apu_responder
// Latency-accurate FPU stand-in on the APU request/response interface.
// Ops with opcode < 8 (ADDMUL) return op0+op1 after ADDMUL_LAT cycles,
// all others return op0^op1^op2 after OTHERS_LAT cycles. Results come back
// in issue order; a short op is held off until it cannot overtake.
// Optional: define CV32E40P_APU_RESP_STALL_EN to add LFSR-driven grant
// backpressure (x^4+x^3+1, seed 4'b1001).
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   apu_req_i/gnt_o     request handshake (gnt combinational)
//   apu_operands_i      NARGS x 32-bit operands, op0 in the low word
//   apu_op_i            opcode
//   apu_flags_i         downstream flags, bits [3:0] echoed in status
//   apu_rvalid_o        one-cycle result pulse
//   apu_result_o        result, zero when no pulse
//   apu_flags_o         {flags_i[3:0], result==0}, zero when no pulse
module cv32e40p_apu_responder
  import cv32e40p_apu_resp_pkg::*;
#(
  parameter int ADDMUL_LAT = 2,
  parameter int OTHERS_LAT = 2,
  parameter int NARGS      = 3,
  parameter int WOP        = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    apu_req_i,
  output logic                    apu_gnt_o,
  input  logic [NARGS*32-1:0]     apu_operands_i,
  input  logic [WOP-1:0]          apu_op_i,
  input  logic [APU_NDSFLAGS-1:0] apu_flags_i,
  output logic                    apu_rvalid_o,
  output logic [31:0]             apu_result_o,
  output logic [APU_NUSFLAGS-1:0] apu_flags_o
);

  localparam int MAXL = (ADDMUL_LAT > OTHERS_LAT) ? ADDMUL_LAT : OTHERS_LAT;

  op_class_e   cls;
  logic [2:0]  lat;
  logic [2:0]  last_rem;
  logic [31:0] op0, op1, op2;
  logic [31:0] res;
  logic        stall;
  slot_t       wr_slot, head, out_q;

  assign op0 = apu_operands_i[31:0];
  assign op1 = apu_operands_i[63:32];

  generate
    if (NARGS >= 3) begin : g_op2
      assign op2 = apu_operands_i[95:64];
    end else begin : g_no_op2
      assign op2 = '0;
    end
  endgenerate

  // Downstream flag bits that are carried on the bus but never used here.
  logic unused_flags;
  assign unused_flags = ^apu_flags_i[APU_NDSFLAGS-1:4];

  assign cls = decode_class(32'(apu_op_i));
  assign lat = (cls == OC_ADDMUL) ? 3'(ADDMUL_LAT) : 3'(OTHERS_LAT);
  assign res = (cls == OC_ADDMUL) ? (op0 + op1) : (op0 ^ op1 ^ op2);

  always_comb begin
    wr_slot        = '0;
    wr_slot.valid  = 1'b1;
    wr_slot.result = res;
    wr_slot.flags  = {apu_flags_i[3:0], (res == 32'd0)};
  end

`ifdef CV32E40P_APU_RESP_STALL_EN
  logic [3:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 4'b1001;
    else       lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Granting only when the new op's latency exceeds the youngest op's
  // remaining distance keeps completion strictly in order and leaves the
  // write slot free after the shift.
  assign apu_gnt_o = apu_req_i && !rst_i && (lat > last_rem) && !stall;

  cv32e40p_apu_resp_slot_pipe #(
    .MAXL (MAXL)
  ) u_pipe (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (apu_gnt_o),
    .wr_idx_i   (lat - 3'd1),
    .wr_slot_i  (wr_slot),
    .head_o     (head),
    .last_rem_o (last_rem)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) out_q <= '0;
    else       out_q <= head;
  end

  assign apu_rvalid_o = out_q.valid;
  assign apu_result_o = out_q.result;
  assign apu_flags_o  = out_q.flags;

endmodule

// File: tb/tb_cv32e40p_apu_responder.sv
// Directed bench: DUT a uses default latencies (2/2), DUT b uses 4/1 to
// exercise the in-order hold-off of a short op behind a long one.
module tb_cv32e40p_apu_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b;
  logic [95:0] ops;
  logic [5:0]  op;
  logic [14:0] flg_i;
  logic        gnt_a, gnt_b, rv_a, rv_b;
  logic [31:0] res_a, res_b;
  logic [4:0]  flg_a, flg_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cv32e40p_apu_responder #(.ADDMUL_LAT(2), .OTHERS_LAT(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .apu_req_i(req_a), .apu_gnt_o(gnt_a),
    .apu_operands_i(ops), .apu_op_i(op), .apu_flags_i(flg_i),
    .apu_rvalid_o(rv_a), .apu_result_o(res_a), .apu_flags_o(flg_a));

  cv32e40p_apu_responder #(.ADDMUL_LAT(4), .OTHERS_LAT(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .apu_req_i(req_b), .apu_gnt_o(gnt_b),
    .apu_operands_i(ops), .apu_op_i(op), .apu_flags_i(flg_i),
    .apu_rvalid_o(rv_b), .apu_result_o(res_b), .apu_flags_o(flg_b));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; op = '0; ops = '0; flg_i = '0;
    tick(); tick();
    tests++; if (gnt_a !== 1'b0) begin fails++; $display("FAIL reset_gnt_a got=%b exp=0", gnt_a); end
    tests++; if (gnt_b !== 1'b0) begin fails++; $display("FAIL reset_gnt_b got=%b exp=0", gnt_b); end
    tests++; if ({rv_a, res_a, flg_a} !== 38'd0) begin fails++; $display("FAIL reset_out_a got=%b/%h/%h exp=0", rv_a, res_a, flg_a); end
    tests++; if ({rv_b, res_b, flg_b} !== 38'd0) begin fails++; $display("FAIL reset_out_b got=%b/%h/%h exp=0", rv_b, res_b, flg_b); end
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    tick();
  endtask

  task automatic test_single_addmul();
    req_a = 1'b1; op = 6'd0; ops = {32'd0, 32'd7, 32'd5}; flg_i = 15'h000A;
    #1;
    tests++; if (gnt_a !== 1'b1) begin fails++; $display("FAIL single_gnt got=%b exp=1", gnt_a); end
    tick(); req_a = 1'b0;
    tests++; if (rv_a !== 1'b0) begin fails++; $display("FAIL single_early1 got=%b exp=0", rv_a); end
    tick();
    tests++; if (rv_a !== 1'b0) begin fails++; $display("FAIL single_early2 got=%b exp=0", rv_a); end
    tick();
    tests++; if (rv_a !== 1'b1 || res_a !== 32'd12 || flg_a !== 5'h14) begin
      fails++; $display("FAIL single_result got=%b/%h/%h exp=1/0000000c/14", rv_a, res_a, flg_a); end
    tick();
    tests++; if (rv_a !== 1'b0 || res_a !== 32'd0) begin fails++; $display("FAIL single_pulse got=%b/%h exp=0/0", rv_a, res_a); end
  endtask

  task automatic test_others_zero();
    req_a = 1'b1; op = 6'd8; ops = {32'd0, 32'hA5A5A5A5, 32'hA5A5A5A5}; flg_i = '0;
    #1;
    tests++; if (gnt_a !== 1'b1) begin fails++; $display("FAIL others_gnt got=%b exp=1", gnt_a); end
    tick(); req_a = 1'b0;
    tick();
    tests++; if (rv_a !== 1'b0) begin fails++; $display("FAIL others_early got=%b exp=0", rv_a); end
    tick();
    tests++; if (rv_a !== 1'b1 || res_a !== 32'd0 || flg_a !== 5'h01) begin
      fails++; $display("FAIL others_result got=%b/%h/%h exp=1/00000000/01", rv_a, res_a, flg_a); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic ev;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        req_a = 1'b1; op = 6'd3; ops = {32'd0, 32'(100*(c+1)), 32'(c+1)}; flg_i = '0;
      end else req_a = 1'b0;
      #1;
      if (c < 4) begin
        tests++; if (gnt_a !== 1'b1) begin fails++; $display("FAIL b2b_gnt c=%0d got=%b exp=1", c, gnt_a); end
      end
      tick();
      ev = (c >= 2) && (c <= 5);
      tests++; if (rv_a !== ev) begin fails++; $display("FAIL b2b_rvalid c=%0d got=%b exp=%b", c, rv_a, ev); end
      if (ev) begin
        tests++; if (res_a !== 32'(101*(c-1))) begin
          fails++; $display("FAIL b2b_result c=%0d got=%0d exp=%0d", c, res_a, 101*(c-1)); end
      end
    end
  endtask

  task automatic test_long_short();
    logic eg, ev;
    logic [31:0] er;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        req_b = 1'b1; op = 6'd0; ops = {32'd0, 32'd2, 32'd1};
      end else if (c <= 4) begin
        req_b = 1'b1; op = 6'd8; ops = {32'd0, 32'd4, 32'd3};
      end else req_b = 1'b0;
      #1;
      if (c <= 4) begin
        eg = (c == 0) || (c == 4);
        tests++; if (gnt_b !== eg) begin fails++; $display("FAIL ls_gnt c=%0d got=%b exp=%b", c, gnt_b, eg); end
      end
      tick();
      ev = (c == 4) || (c == 5);
      er = (c == 4) ? 32'd3 : ((c == 5) ? 32'd7 : 32'd0);
      tests++; if (rv_b !== ev || res_b !== er) begin
        fails++; $display("FAIL ls_out c=%0d got=%b/%0d exp=%b/%0d", c, rv_b, res_b, ev, er); end
    end
  endtask

  task automatic test_reset_mid_op();
    logic eg, ev;
    logic [31:0] er;
    for (int c = 0; c < 6; c++) begin
      rst = (c == 1);
      if (c == 0) begin
        req_a = 1'b1; op = 6'd0; ops = {32'd0, 32'd20, 32'd10};
      end else if (c <= 2) begin
        req_a = 1'b1; op = 6'd0; ops = {32'd0, 32'd1, 32'd1};
      end else req_a = 1'b0;
      #1;
      if (c <= 2) begin
        eg = (c != 1);
        tests++; if (gnt_a !== eg) begin fails++; $display("FAIL rstmid_gnt c=%0d got=%b exp=%b", c, gnt_a, eg); end
      end
      tick();
      ev = (c == 4);
      er = ev ? 32'd2 : 32'd0;
      tests++; if (rv_a !== ev || res_a !== er || (!ev && flg_a !== 5'd0)) begin
        fails++; $display("FAIL rstmid_out c=%0d got=%b/%0d/%h exp=%b/%0d", c, rv_a, res_a, flg_a, ev, er); end
    end
    rst = 1'b0;
  endtask

  task automatic test_stall();
    logic [3:0] lf;
    logic       g [34];
    logic       ev;
    rst = 1'b1; tick(); rst = 1'b0;
    lf = 4'b1001;
    for (int c = 0; c < 34; c++) begin
      g[c] = 1'b0;
      if (c < 32) begin
        req_a = 1'b1; op = 6'd1; ops = {32'd0, 32'(c), 32'd1}; flg_i = '0;
      end else req_a = 1'b0;
      #1;
      if (c < 32) begin
        g[c] = ~lf[0];
        tests++; if (gnt_a !== g[c]) begin fails++; $display("FAIL stall_gnt c=%0d got=%b exp=%b", c, gnt_a, g[c]); end
      end
      tick();
      lf = {lf[2:0], lf[3] ^ lf[2]};
      ev = (c >= 2) ? g[c-2] : 1'b0;
      tests++; if (rv_a !== ev) begin fails++; $display("FAIL stall_rvalid c=%0d got=%b exp=%b", c, rv_a, ev); end
      if (ev) begin
        tests++; if (res_a !== 32'(c-1)) begin fails++; $display("FAIL stall_result c=%0d got=%0d exp=%0d", c, res_a, c-1); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; ops = '0; op = '0; flg_i = '0;
    test_reset();
`ifdef CV32E40P_APU_RESP_STALL_EN
    test_stall();
`else
    test_single_addmul();
    test_others_zero();
    test_back_to_back();
    tick(); tick();
    test_long_short();
    tick();
    test_reset_mid_op();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cv32e40p_apu_responder.md
Name: cv32e40p_apu_responder

Overview:
- Responder end of the core's APU (auxiliary processing unit) request/response interface.
- Accepts FP-class requests from the core's ex-stage APU initiator. Returns results in order after a fixed per-class latency, mirroring the FPU_ADDMUL_LAT / FPU_OTHERS_LAT values of the active core config.
- Used as a latency-accurate FPU stand-in for lint, FPU-latency configs and core-level simulation without fpnew.

Parameters:
- ADDMUL_LAT, 2, cycles from grant to rvalid for ADDMUL-class ops; legal range 1..4.
- OTHERS_LAT, 2, cycles from grant to rvalid for OTHERS-class ops; legal range 1..4.
- NARGS, 3, number of 32-bit operands.
- WOP, 6, opcode width.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset, synchronous, active-high.
- apu_req_i  in  1  request valid.
- apu_gnt_o  out  1  request accepted this cycle (req && gnt = handshake).
- apu_operands_i  in  NARGS*32  operands; op0 = bits[31:0], op1 = [63:32], op2 = [95:64].
- apu_op_i  in  WOP  opcode.
- apu_flags_i  in  15  downstream flags (rounding mode etc.); captured, not interpreted.
- apu_rvalid_o  out  1  one-cycle result-valid pulse.
- apu_result_o  out  32  result, valid only while apu_rvalid_o = 1.
- apu_flags_o  out  5  status flags, valid only while apu_rvalid_o = 1.

Behaviour:
- Reset: rst_i sampled on rising clk_i.
  - Clears all pipeline slots.
  - apu_rvalid_o = 0, apu_result_o = 0, apu_flags_o = 0.
  - Stall counter cleared.
  - apu_gnt_o is combinational and must read 0 while rst_i = 1.
- Op class decode:
  - apu_op_i < 8 → ADDMUL, latency L = ADDMUL_LAT.
  - Otherwise → OTHERS, latency L = OTHERS_LAT.
- Result function, computed at accept:
  - ADDMUL: op0 + op1 (mod 2^32).
  - OTHERS: op0 ^ op1 ^ op2.
- Flags:
  - apu_flags_o[0] = (result == 0).
  - apu_flags_o[4:1] = apu_flags_i[3:0] captured at accept.
- Pipeline:
  - MAXL = max(ADDMUL_LAT, OTHERS_LAT) slots, slot k completes k cycles from now.
  - An accepted op is written into slot L-1 in the accept cycle.
  - Slots shift toward slot 0 each cycle.
  - Slot 0 content drives the outputs registered, so rvalid rises exactly L cycles after the handshake edge.
- Ordering rule (in-order completion required by the core):
  - last_rem = cycles until the youngest outstanding op completes; 0 when the pipe is empty.
  - apu_gnt_o = apu_req_i && !rst_i && (L > last_rem) && !stall.
  - An equal-latency op in consecutive cycles is always grantable (back-to-back throughput 1/cycle).
  - A short op behind a long op is held off until it cannot overtake.
- Gnt may be combinational on apu_req_i/apu_op_i. The core holds req/op/operands stable until gnt.
- Operands are sampled only on the handshake edge.
- Simultaneous accept and completion in the same cycle is legal and lossless.
- Reset mid-operation: all in-flight ops are discarded and no rvalid is produced for them. The first grant is possible in the cycle after rst_i falls.
- apu_rvalid_o never asserts for two ops in the same cycle.
- Gaps between rvalid pulses equal the gaps between grants when latencies are equal.

Optional Feature:
- Macro: CV32E40P_APU_RESP_STALL_EN.
- When defined:
  - A 4-bit LFSR is added, polynomial x^4+x^3+1, seed 4'b1001 on reset, advancing every cycle.
  - stall = lfsr[0]. This inserts pseudo-random grant backpressure; latency after grant is unchanged.
- When undefined:
  - stall = 0 and no LFSR logic is present.
  - Grant depends only on req and the ordering rule.

Decomposition:
- Package cv32e40p_apu_resp_pkg:
  - op_class_e (ADDMUL, OTHERS).
  - ADDMUL_OP_LIMIT = 8.
  - APU_NUSFLAGS = 5, APU_NDSFLAGS = 15.
  - slot_t struct {valid, result[31:0], flags[4:0]}.
- One sub-module: cv32e40p_apu_resp_slot_pipe.
  - MAXL-deep shift pipe with indexed write port (slot L-1) and last_rem counter output.
- Top level holds decode, result function, grant logic and the optional LFSR.

Test Plan:
- Reset then single ADDMUL, op=0, op0=5, op1=7, ADDMUL_LAT=2 → gnt in same cycle; rvalid exactly 2 cycles later, result=12, flags[0]=0.
- OTHERS op=8, op0=op1=0xA5A5A5A5, op2=0 → result 0, flags[0]=1 after OTHERS_LAT.
- Four back-to-back ADDMUL requests, req held high → 4 consecutive grants; 4 consecutive rvalid pulses in issue order with the correct sums.
- ADDMUL_LAT=4, OTHERS_LAT=1: long op followed immediately by short op → short op's gnt withheld 3 cycles; rvalids in order, never coincident.
- rst_i asserted one cycle after a grant → no rvalid for that op; outputs 0; next request granted the cycle after rst_i drops.
- With CV32E40P_APU_RESP_STALL_EN: req held high for 32 cycles → grant pattern matches the LFSR reference sequence; every granted op returns after exactly L cycles.
